hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Decode-stage companion to the EX/MEM forwarding logic. It detects register hazards that forwarding cannot resolve and stalls the front end.
- Forwarding resolves what the pipeline can bypass. This block resolves what it cannot: load-use distance, and results from the multi-cycle MAC unit used for NN layers.
- It keeps a per-register pending scoreboard and a single-outstanding MAC tracker. It drives stall (hold PC and IF/ID) and bubble (insert a NOP into ID/EX).

Parameters:
- NREG, 16, number of architectural registers; r0 is hard-wired zero.
- RW, 4, register address width.
- LOAD_STALL, 1, cycles after a load issues during which its rd cannot be forwarded (1..3).
- CW, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  RW  source register A
- id_rt  in  RW  source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_rd  in  RW  destination register
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- id_longop  in  1  instruction is a MAC (multi-cycle)
- flush  in  1  branch taken; kill the ID instruction this cycle
- mac_done  in  1  MAC unit result is written back this cycle
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control (equals stall)
- mac_busy  out  1  MAC in flight
- stall_cycles  out  CW  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset clears all state:
  - pend_cnt[*]=0, mac_busy=0, mac_rd=0, stall_cycles=0.
  - stall=bubble=0 in the first cycle after reset, regardless of inputs, because all pending state is zero.
- src_hazard(r) = (r!=0) & (pend_cnt[r]!=0 | (mac_busy & !mac_done & mac_rd==r)).
- A mac_done in cycle t makes the MAC result forwardable in cycle t. The hazard therefore drops combinationally in the same cycle.
- stall (combinational) = id_valid & !flush & (any of the following):
  - id_uses_rs & src_hazard(id_rs)
  - id_uses_rt & src_hazard(id_rt)
  - id_regwrite & id_rd!=0 & mac_busy & !mac_done & id_rd==mac_rd (WAW against MAC)
  - id_longop & mac_busy & !mac_done (structural: one MAC at a time)
- bubble = stall.
- issue = id_valid & !flush & !stall.
- Scoreboard update each cycle, for every r:
  - Reload: if issue & id_regwrite & id_memread & id_rd==r & r!=0, then pend_cnt[r] <= LOAD_STALL. Reload takes priority over decrement.
  - Otherwise, if pend_cnt[r]!=0, pend_cnt[r] decrements by 1.
  - Writes to r0 are never tracked.
- MAC tracker:
  - Start: if issue & id_longop, then mac_busy<=1 and mac_rd<=id_rd. This applies even when id_rd==0, as a structural occupancy.
  - Done: else if mac_done, then mac_busy<=0.
  - Same-cycle mac_done and new longop issue: mac_busy stays 1 and mac_rd takes the new rd.
  - A mac_done while mac_busy=0 is ignored.
- Flush:
  - The ID instruction does not issue, and stall=0.
  - In-flight state (counters, MAC tracker) continues unchanged.
- Stall counter: stall_cycles increments each cycle stall=1 and saturates at all-ones.
- Latency:
  - A load followed directly by a dependent instruction produces exactly LOAD_STALL stall cycles.
  - With one independent instruction between them, it produces max(LOAD_STALL-1,0) stall cycles.
- Reset mid-operation: a pending MAC is forgotten. The MAC unit must be reset by the same rst.

Test Plan:
- Load-use: LW r3 issues; next cycle ADD uses rs=r3 (LOAD_STALL=1) -> stall=1 for exactly 1 cycle, then ADD issues and stall_cycles=1.
- Independent sequence: LW r3 then ADD r5,r6 -> no stall. Load to r0 then use r0 -> no stall.
- MAC dependency: MAC r7 issues; reader of r7 in ID for 5 cycles; mac_done pulses on cycle 5 -> stall=1 for cycles 1-4, stall=0 on cycle 5 with issue, mac_busy=0 on cycle 6.
- Structural/WAW: while MAC r7 is busy, a second MAC (rd=r2) stalls until mac_done. A non-MAC write to r7 stalls. A write to r8 does not stall. mac_done same cycle as a new MAC issue -> mac_busy stays 1 and mac_rd=r2.
- Flush: load-use stall condition with flush=1 -> stall=0, no issue, pend_cnt continues decrementing. Next cycle with no hazard -> no stall.
- Reset: assert rst with mac_busy=1 and pend_cnt[4]=1 -> next cycle mac_busy=0, stall_cycles=0, and a reader of r4 does not stall. Saturation: force 2^CW+3 stall cycles -> stall_cycles=all-ones.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: stalls the front end on load-use distance and on
// results, WAW or structural conflicts with the single in-flight multi-cycle MAC.
module hazard_stall_unit #(
  parameter int unsigned NREG       = 16,
  parameter int unsigned RW         = 4,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_longop,
  input  logic          flush,
  input  logic          mac_done,
  output logic          stall,
  output logic          bubble,
  output logic          mac_busy,
  output logic [CW-1:0] stall_cycles
);

  // Pending counters only need to hold LOAD_STALL (at most 3).
  localparam int unsigned PW = 2;

  logic [NREG-1:0][PW-1:0] pend_q, pend_d;
  logic                    mac_busy_q, mac_busy_d;
  logic [RW-1:0]           mac_rd_q, mac_rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic            mac_live;
  logic [NREG-1:0] haz_vec;
  logic            issue;
  logic            load_issue;

  // Per-register "cannot be bypassed this cycle" vector; a finishing MAC is forwardable.
  always_comb begin
    mac_live = mac_busy_q & ~mac_done;
    haz_vec  = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      haz_vec[r] = (r != 0) &&
                   ((pend_q[r] != '0) || (mac_live && (mac_rd_q == RW'(r))));
    end
  end

  always_comb begin
    stall = id_valid & ~flush &
            ((id_uses_rs & haz_vec[id_rs]) |
             (id_uses_rt & haz_vec[id_rt]) |
             (id_regwrite & (id_rd != '0) & mac_live & (id_rd == mac_rd_q)) |
             (id_longop & mac_live));
    bubble     = stall;
    issue      = id_valid & ~flush & ~stall;
    load_issue = issue & id_regwrite & id_memread;
  end

  // Next-state: scoreboard reload/decrement, MAC occupancy, saturating stall counter.
  always_comb begin
    pend_d     = pend_q;
    mac_busy_d = mac_busy_q;
    mac_rd_d   = mac_rd_q;
    cnt_d      = cnt_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (load_issue && (id_rd == RW'(r))) begin
        pend_d[r] = PW'(LOAD_STALL);
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PW'(1);
      end
    end
    if (issue && id_longop) begin
      mac_busy_d = 1'b1;
      mac_rd_d   = id_rd;
    end else if (mac_done) begin
      mac_busy_d = 1'b0;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      mac_busy_q <= 1'b0;
      mac_rd_q   <= '0;
      cnt_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      mac_busy_q <= mac_busy_d;
      mac_rd_q   <= mac_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mac_busy     = mac_busy_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vector table, saturation run, and random
// stimulus against a model that tracks the last cycle each register is unforwardable.
module tb_hazard_stall_unit;

  localparam int unsigned NREG = 16;
  localparam int unsigned RW   = 4;
  localparam int unsigned LS   = 1;
  localparam int unsigned CW   = 8;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic          rst;
    logic          valid;
    logic [RW-1:0] rs;
    logic          urs;
    logic [RW-1:0] rt;
    logic          urt;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          lo;
    logic          fl;
    logic          md;
  } vin_t;

  typedef struct {
    vin_t in;
    logic st;
    logic busy;
    int   sc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_longop;
  logic          flush, mac_done;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          stall, bubble, mac_busy;
  logic [CW-1:0] stall_cycles;

  hazard_stall_unit #(.NREG(NREG), .RW(RW), .LOAD_STALL(LS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_longop(id_longop),
    .flush(flush), .mac_done(mac_done), .stall(stall), .bubble(bubble),
    .mac_busy(mac_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a register is unforwardable through cycle ld_last[r].
  int ld_last [NREG];
  int cyc;
  bit m_busy;
  int m_rd;
  int m_sc;

  function automatic void model_reset();
    for (int i = 0; i < int'(NREG); i++) ld_last[i] = -1000;
    m_busy = 1'b0;
    m_rd   = 0;
    m_sc   = 0;
  endfunction

  function automatic bit blocked(input int r, input bit md);
    return (r != 0) && ((ld_last[r] >= cyc) || (m_busy && !md && m_rd == r));
  endfunction

  function automatic bit model_stall(input vin_t v);
    bit live;
    live = m_busy && !v.md;
    if (!v.valid || v.fl) return 1'b0;
    return (v.urs && blocked(int'(v.rs), v.md)) ||
           (v.urt && blocked(int'(v.rt), v.md)) ||
           (v.rw && v.rd != 0 && live && int'(v.rd) == m_rd) ||
           (v.lo && live);
  endfunction

  function automatic void model_update(input vin_t v, input bit st);
    bit iss;
    if (v.rst) begin
      model_reset();
    end else begin
      iss = v.valid && !v.fl && !st;
      if (iss && v.rw && v.mr && v.rd != 0) ld_last[v.rd] = cyc + int'(LS);
      if (iss && v.lo) begin
        m_busy = 1'b1;
        m_rd   = int'(v.rd);
      end else if (v.md) begin
        m_busy = 1'b0;
      end
      if (st && m_sc < SAT) m_sc++;
    end
    cyc++;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vin_t v);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_uses_rs = v.urs;
    id_rt = v.rt; id_uses_rt = v.urt; id_rd = v.rd; id_regwrite = v.rw;
    id_memread = v.mr; id_longop = v.lo; flush = v.fl; mac_done = v.md;
  endtask

  // One cycle: drive at negedge, sample mid-cycle, advance model at posedge.
  task automatic cycle(input vin_t v, input bit use_tab, input logic e_st,
                       input logic e_busy, input int e_sc);
    bit mst;
    drive(v);
    #1;
    mst = model_stall(v);
    if (use_tab) begin
      chk("tab_stall", int'(stall), int'(e_st));
      chk("tab_busy", int'(mac_busy), int'(e_busy));
      chk("tab_cycles", int'(stall_cycles), e_sc);
    end else begin
      chk("stall", int'(stall), int'(mst));
      chk("busy", int'(mac_busy), int'(m_busy));
      chk("cycles", int'(stall_cycles), m_sc);
    end
    chk("bubble", int'(bubble), int'(stall));
    @(posedge clk);
    model_update(v, mst);
    @(negedge clk);
  endtask

  function automatic vin_t mk(input bit r, input bit va, input int rs, input bit urs,
                              input int rt, input bit urt, input int rd, input bit rw,
                              input bit mr, input bit lo, input bit fl, input bit md);
    vin_t v;
    v.rst = r; v.valid = va; v.rs = RW'(rs); v.urs = urs; v.rt = RW'(rt); v.urt = urt;
    v.rd = RW'(rd); v.rw = rw; v.mr = mr; v.lo = lo; v.fl = fl; v.md = md;
    return v;
  endfunction

  vec_t tab[$];

  task automatic add(input vin_t v, input logic st, input logic b, input int sc);
    vec_t e;
    e.in = v; e.st = st; e.busy = b; e.sc = sc;
    tab.push_back(e);
  endtask

  initial begin
    vin_t nop, v;
    nop = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    model_reset();
    cyc = 0;
    drive(nop);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //     rst va rs urs rt urt rd rw mr lo fl md        st busy sc
    add(mk(0,1,0,0,0,0,3,1,1,0,0,0),  0,0,0);   // LW r3
    add(mk(0,1,3,1,0,0,5,1,0,0,0,0),  1,0,0);   // ADD uses r3: load-use stall
    add(mk(0,1,3,1,0,0,5,1,0,0,0,0),  0,0,1);   // issues after one stall
    add(mk(0,1,0,0,0,0,3,1,1,0,0,0),  0,0,1);   // LW r3
    add(mk(0,1,5,1,6,1,7,1,0,0,0,0),  0,0,1);   // independent ADD
    add(mk(0,1,0,0,0,0,0,1,1,0,0,0),  0,0,1);   // load to r0
    add(mk(0,1,0,1,0,1,9,1,0,0,0,0),  0,0,1);   // reader of r0
    add(mk(0,1,0,0,0,0,7,1,0,1,0,0),  0,0,1);   // MAC r7
    add(mk(0,1,7,1,0,0,10,1,0,0,0,0), 1,1,1);
    add(mk(0,1,7,1,0,0,10,1,0,0,0,0), 1,1,2);
    add(mk(0,1,7,1,0,0,10,1,0,0,0,0), 1,1,3);
    add(mk(0,1,7,1,0,0,10,1,0,0,0,0), 1,1,4);
    add(mk(0,1,7,1,0,0,10,1,0,0,0,1), 0,1,5);   // mac_done: same-cycle release
    add(nop,                          0,0,5);
    add(mk(0,1,0,0,0,0,7,1,0,1,0,0),  0,0,5);   // MAC r7
    add(mk(0,1,0,0,0,0,2,1,0,1,0,0),  1,1,5);   // second MAC: structural
    add(mk(0,1,0,0,0,0,7,1,0,0,0,0),  1,1,6);   // WAW on r7
    add(mk(0,1,0,0,0,0,8,1,0,0,0,0),  0,1,7);   // write r8: fine
    add(mk(0,1,0,0,0,0,2,1,0,1,0,1),  0,1,7);   // done + new MAC r2
    add(mk(0,1,2,1,0,0,0,0,0,0,0,0),  1,1,7);   // r2 now tracked
    add(mk(0,1,0,0,7,1,9,1,0,0,0,0),  0,1,8);   // r7 no longer tracked
    add(mk(0,0,0,0,0,0,0,0,0,0,0,1),  0,1,8);
    add(nop,                          0,0,8);
    add(mk(0,1,0,0,0,0,4,1,1,0,0,0),  0,0,8);   // LW r4
    add(mk(0,1,4,1,0,0,0,0,0,0,1,0),  0,0,8);   // flushed reader
    add(mk(0,1,4,1,0,0,0,0,0,0,0,0),  0,0,8);   // counter drained during flush
    add(mk(0,1,0,0,0,0,6,1,0,1,0,0),  0,0,8);   // MAC r6
    add(mk(0,1,0,0,0,0,4,1,1,0,0,0),  0,1,8);   // LW r4
    add(mk(1,1,4,1,0,0,0,0,0,0,0,0),  1,1,8);   // reset with pending state
    add(mk(0,1,4,1,0,0,0,0,0,0,0,0),  0,0,0);
    add(mk(0,1,6,1,0,0,0,0,0,0,0,0),  0,0,0);

    foreach (tab[i]) cycle(tab[i].in, 1'b1, tab[i].st, tab[i].busy, tab[i].sc);

    // Saturation: hold a reader of a busy MAC target for 2^CW+3 cycles.
    cycle(mk(0,1,0,0,0,0,1,1,0,1,0,0), 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < (1 << CW) + 3; i++) cycle(mk(0,1,1,1,0,0,0,0,0,0,0,0), 1'b0, 1'b0, 1'b0, 0);
    cycle(mk(0,1,1,1,0,0,0,0,0,0,0,1), 1'b1, 1'b0, 1'b1, SAT);
    cycle(nop, 1'b1, 1'b0, 1'b0, SAT);
    cycle(mk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, 1'b0, SAT);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.valid = ($urandom_range(0, 9) != 0);
      v.rs    = RW'($urandom_range(0, 5));
      v.rt    = RW'($urandom_range(0, 5));
      v.rd    = RW'($urandom_range(0, 5));
      v.urs   = 1'($urandom_range(0, 1));
      v.urt   = 1'($urandom_range(0, 1));
      v.rw    = ($urandom_range(0, 3) != 0);
      v.mr    = ($urandom_range(0, 2) == 0);
      v.lo    = ($urandom_range(0, 6) == 0);
      v.fl    = ($urandom_range(0, 7) == 0);
      v.md    = ($urandom_range(0, 5) == 0);
      cycle(v, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
